pulse_source: RTL and testbench

Parametrised multi-channel digital stimulus source for the gEDA digital section, the clocked successor to the constant voltage/battery source mappings. Each channel produces a DC level, continuous PWM, or a one-shot pulse, with period and high time set at runtime through a valid/ready config port. New settings are double-buffered so a running waveform changes only on a period boundary and never glitches.

---
 rtl/pulse_source_pkg.sv | 24 ++
 rtl/pulse_channel.sv | 101 ++++++++++
 rtl/pulse_source.sv | 50 +++++
 tb/tb_pulse_source.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_source_pkg.sv
// Shared types for the pulse_source stimulus generator: channel modes and the
// default-width configuration record.
package pulse_source_pkg;

  localparam int PS_WIDTH = 16;

  typedef enum logic [1:0] {
    DC_LOW  = 2'd0,
    DC_HIGH = 2'd1,
    PWM     = 2'd2,
    ONESHOT = 2'd3
  } mode_e;

  typedef struct packed {
    mode_e                mode;
    logic [PS_WIDTH-1:0]  period;
    logic [PS_WIDTH-1:0]  high;
  } cfg_t;

  function automatic logic is_timed(mode_e m);
    return (m == PWM) || (m == ONESHOT);
  endfunction

endpackage

// File: rtl/pulse_channel.sv
// One output channel: shadow/active config, enable register, period counter,
// one-shot done flag and the registered-only out/wrap decode.
module pulse_channel
  import pulse_source_pkg::*;
#(
  parameter int WIDTH = PS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_i,
  input  logic             enable_i,
  input  mode_e            mode_i,
  input  logic [WIDTH-1:0] period_i,
  input  logic [WIDTH-1:0] high_i,
  output logic             pending_o,
  output logic             out_o,
  output logic             wrap_o,
  output logic             done_o
);

  typedef struct packed {
    mode_e            mode;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high;
  } ch_cfg_t;

  ch_cfg_t          act_q, act_d, shd_q, shd_d, req;
  logic             en_q;
  logic             done_q, done_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             counting, last, idle, xfer;

  assign req       = {mode_i, period_i, high_i};
  // A zero period degenerates to DC_LOW: no counting, no wrap.
  assign counting  = is_timed(act_q.mode) && (act_q.period != '0);
  assign last      = (cnt_q == act_q.period - WIDTH'(1));
  assign wrap_o    = en_q && counting && !done_q && last;
  assign out_o     = en_q && ((act_q.mode == DC_HIGH) ||
                              (counting && !done_q && (cnt_q < act_q.high)));
  assign idle      = !en_q || !counting || done_q;
  assign xfer      = wr_i && !pend_q;
  assign pending_o = pend_q;
  assign done_o    = done_q;

  always_comb begin
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    if (en_q && counting && !done_q) begin
      if (last) begin
        if (act_q.mode == ONESHOT) done_d = 1'b1;
        else                       cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
    // A write landing on the wrap cycle skips the shadow entirely.
    if (xfer && wrap_o) begin
      act_d  = req;
      cnt_d  = '0;
      done_d = 1'b0;
    end else begin
      if (pend_q && (idle || wrap_o)) begin
        act_d  = shd_q;
        pend_d = 1'b0;
        cnt_d  = '0;
        done_d = 1'b0;
      end
      if (xfer) begin
        shd_d  = req;
        pend_d = 1'b1;
      end
    end
    if (!enable_i) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q  <= '0;
      shd_q  <= '0;
      pend_q <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      en_q   <= enable_i;
    end
  end

endmodule

// File: rtl/pulse_source.sv
// Multi-channel DC/PWM/one-shot stimulus source with a shared valid/ready
// config port; channel select decode and ready mux live here.
module pulse_source
  import pulse_source_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int WIDTH    = PS_WIDTH,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [WIDTH-1:0]    cfg_period,
  input  logic [WIDTH-1:0]    cfg_high,
  input  logic [CHANNELS-1:0] enable,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] wrap,
  output logic [CHANNELS-1:0] done
);

  logic [CHANNELS-1:0] pend;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pulse_channel #(.WIDTH(WIDTH)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .wr_i      (cfg_valid && (cfg_ch == CH_W'(g))),
      .enable_i  (enable[g]),
      .mode_i    (mode_e'(cfg_mode)),
      .period_i  (cfg_period),
      .high_i    (cfg_high),
      .pending_o (pend[g]),
      .out_o     (out[g]),
      .wrap_o    (wrap[g]),
      .done_o    (done[g])
    );
  end

  // Out-of-range channel numbers are always ready so they drain harmlessly.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = !pend[i];
    end
  end

endmodule

// File: tb/tb_pulse_source.sv
// Directed bench for pulse_source: a period/age-based behavioural model checked
// every cycle, plus hand-written waveform expectations.
module tb_pulse_source;
  import pulse_source_pkg::*;

  localparam int NCH = 5;
  localparam int W   = 16;
  localparam int CW  = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [CW-1:0]  cfg_ch = '0;
  logic [1:0]     cfg_mode = '0;
  logic [W-1:0]   cfg_period = '0;
  logic [W-1:0]   cfg_high = '0;
  logic [NCH-1:0] enable = '0;
  logic [NCH-1:0] out, wrap, done;

  int n_vec = 0;
  int n_err = 0;

  pulse_source #(.CHANNELS(NCH), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
    .cfg_high(cfg_high), .enable(enable), .out(out), .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

  // Model: each channel remembers how many cycles it has been running under
  // its current settings; position and done are derived from that age.
  int m_en[NCH], m_age[NCH], m_mode[NCH], m_per[NCH], m_hi[NCH];
  int m_pend[NCH], s_mode[NCH], s_per[NCH], s_hi[NCH];

  initial begin
    for (int c = 0; c < NCH; c++) begin
      m_en[c] = 0; m_age[c] = 0; m_mode[c] = 0; m_per[c] = 0; m_hi[c] = 0;
      m_pend[c] = 0; s_mode[c] = 0; s_per[c] = 0; s_hi[c] = 0;
    end
  end

  function automatic bit m_run(int c);
    return m_en[c] != 0 && (m_mode[c] == 2 || m_mode[c] == 3) && m_per[c] > 0;
  endfunction

  function automatic bit m_done(int c);
    return m_run(c) && m_mode[c] == 3 && m_age[c] >= m_per[c];
  endfunction

  function automatic int m_pos(int c);
    if (m_per[c] == 0) return 0;
    if (m_mode[c] == 2) return m_age[c] % m_per[c];
    return (m_age[c] < m_per[c]) ? m_age[c] : m_per[c] - 1;
  endfunction

  function automatic bit m_wrap(int c);
    return m_run(c) && !m_done(c) && m_pos(c) == m_per[c] - 1;
  endfunction

  function automatic bit m_out(int c);
    return m_en[c] != 0 &&
           (m_mode[c] == 1 || (m_run(c) && !m_done(c) && m_pos(c) < m_hi[c]));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_en[c] = 0; m_age[c] = 0; m_mode[c] = 0; m_per[c] = 0; m_hi[c] = 0;
        m_pend[c] = 0; s_mode[c] = 0; s_per[c] = 0; s_hi[c] = 0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        bit w, idl, take, applied;
        w       = m_wrap(c);
        idl     = !m_run(c) || m_done(c);
        take    = cfg_valid && int'(cfg_ch) == c && m_pend[c] == 0;
        applied = 0;
        if (take && w) begin
          m_mode[c] = int'(cfg_mode); m_per[c] = int'(cfg_period); m_hi[c] = int'(cfg_high);
          applied = 1;
        end else if (m_pend[c] != 0 && (idl || w)) begin
          m_mode[c] = s_mode[c]; m_per[c] = s_per[c]; m_hi[c] = s_hi[c];
          m_pend[c] = 0;
          applied = 1;
        end else if (take) begin
          s_mode[c] = int'(cfg_mode); s_per[c] = int'(cfg_period); s_hi[c] = int'(cfg_high);
          m_pend[c] = 1;
        end
        if (!enable[c] || m_en[c] == 0 || applied) m_age[c] = 0;
        else m_age[c] = m_age[c] + 1;
        m_en[c] = enable[c] ? 1 : 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [NCH-1:0] eo, ew, ed;
    logic er;
    int idx;
    for (int c = 0; c < NCH; c++) begin
      eo[c] = m_out(c);
      ew[c] = m_wrap(c);
      ed[c] = m_done(c);
    end
    idx = int'(cfg_ch);
    er  = (idx < NCH) ? (m_pend[idx] == 0) : 1'b1;
    chk("model_out",   32'(out),       32'(eo));
    chk("model_wrap",  32'(wrap),      32'(ew));
    chk("model_done",  32'(done),      32'(ed));
    chk("model_ready", 32'(cfg_ready), 32'(er));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic cfg(input int ch, input mode_e m, input int per, input int hi);
    cfg_ch     = CW'(ch);
    cfg_mode   = 2'(m);
    cfg_period = W'(per);
    cfg_high   = W'(hi);
    cfg_valid  = 1'b1;
    tick(1);
    cfg_valid  = 1'b0;
  endtask

  initial begin
    logic [15:0] pat_o, pat_w, pat_d;

    tick(3);
    chk("rst_out",   32'(out),       32'h0);
    chk("rst_wrap",  32'(wrap),      32'h0);
    chk("rst_done",  32'(done),      32'h0);
    chk("rst_ready", 32'(cfg_ready), 32'h1);
    rst = 1'b0;
    tick(1);

    // Ch0 PWM period 4 high 1: out 1,0,0,0 and wrap on the 4th cycle.
    cfg(0, PWM, 4, 1);
    tick(1);
    enable[0] = 1'b1;
    tick(1);
    pat_o = 16'h0011; pat_w = 16'h0088;
    for (int k = 0; k < 8; k++) begin
      chk("ch0_pwm_out",  32'(out[0]),  32'(pat_o[k]));
      chk("ch0_pwm_wrap", 32'(wrap[0]), 32'(pat_w[k]));
      tick(1);
    end

    // Reconfigure at cnt=1: old 0,0 tail then 1,1,0 repeating.
    tick(1);
    cfg(0, PWM, 3, 2);
    pat_o = 16'h006C;
    for (int k = 0; k < 8; k++) begin
      chk("ch0_recfg_out", 32'(out[0]), 32'(pat_o[k]));
      if (k == 0) chk("ch0_ready_pend", 32'(cfg_ready), 32'h0);
      if (k == 2) chk("ch0_ready_free", 32'(cfg_ready), 32'h1);
      tick(1);
    end

    // Ch1 ONESHOT period 5 high 3.
    cfg(1, ONESHOT, 5, 3);
    tick(1);
    enable[1] = 1'b1;
    tick(1);
    pat_o = 16'h0007; pat_w = 16'h0010; pat_d = 16'h03E0;
    for (int k = 0; k < 10; k++) begin
      chk("ch1_os_out",  32'(out[1]),  32'(pat_o[k]));
      chk("ch1_os_wrap", 32'(wrap[1]), 32'(pat_w[k]));
      chk("ch1_os_done", 32'(done[1]), 32'(pat_d[k]));
      tick(1);
    end
    cfg(1, PWM, 2, 1);
    chk("ch1_done_held", 32'(done[1]), 32'h1);
    tick(1);
    chk("ch1_done_clr", 32'(done[1]), 32'h0);
    chk("ch1_new_out",  32'(out[1]),  32'h1);

    // Ch2: zero period, then high beyond period.
    enable[2] = 1'b1;
    cfg(2, PWM, 0, 5);
    tick(1);
    for (int k = 0; k < 6; k++) begin
      chk("ch2_p0", 32'({out[2], wrap[2]}), 32'h0);
      tick(1);
    end
    cfg(2, PWM, 4, 7);
    tick(1);
    pat_w = 16'h0088;
    for (int k = 0; k < 8; k++) begin
      chk("ch2_hi_out",  32'(out[2]),  32'h1);
      chk("ch2_hi_wrap", 32'(wrap[2]), 32'(pat_w[k]));
      tick(1);
    end

    // Out-of-range channel number is accepted and ignored.
    enable[4]  = 1'b1;
    cfg_ch     = CW'(NCH);
    cfg_mode   = 2'(DC_HIGH);
    cfg_period = W'(9);
    cfg_high   = W'(9);
    cfg_valid  = 1'b1;
    #1;
    chk("oor_ready", 32'(cfg_ready), 32'h1);
    tick(1);
    cfg_valid = 1'b0;
    tick(2);
    chk("oor_ch4_out", 32'(out[4]), 32'h0);

    // Ch3: transfer in the exact wrap cycle bypasses the shadow.
    cfg(3, PWM, 4, 1);
    tick(1);
    enable[3] = 1'b1;
    tick(1);
    tick(3);
    chk("ch3_at_wrap", 32'(wrap[3]), 32'h1);
    cfg(3, PWM, 3, 2);
    chk("ch3_no_pend", 32'(cfg_ready), 32'h1);
    pat_o = 16'h001B; pat_w = 16'h0024;
    for (int k = 0; k < 6; k++) begin
      chk("ch3_byp_out",  32'(out[3]),  32'(pat_o[k]));
      chk("ch3_byp_wrap", 32'(wrap[3]), 32'(pat_w[k]));
      tick(1);
    end

    // Enable falling forces the channel low on the next edge.
    enable[0] = 1'b0;
    tick(1);
    chk("ch0_dis_out", 32'(out[0]), 32'h0);
    tick(3);

    // Asynchronous reset in mid-cycle.
    chk("pre_rst_ch2", 32'(out[2]), 32'h1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_out",   32'(out),       32'h0);
    chk("arst_wrap",  32'(wrap),      32'h0);
    chk("arst_done",  32'(done),      32'h0);
    chk("arst_ready", 32'(cfg_ready), 32'h1);
    tick(2);
    rst = 1'b0;
    tick(4);
    chk("post_rst_out", 32'(out), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
